// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one downstream memory request port between M0 (LSU data port,
//   high priority) and M1 (IFU fetch port). A grant FSM picks a requester in
//   IDLE and holds it until the downstream completes, the requester withdraws,
//   or the watchdog expires. A starvation counter forces M1 after STARVE_LIM
//   consecutive M0 grants while M1 is pending.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_m0_*, o_m0_*      M0 request fields in, ready pulse / read data out
//   i_m1_*, o_m1_*      M1 request fields in, ready pulse / read data out
//   o_s_*, i_s_*        downstream request out, completion pulse / data in
//   o_busy              FSM not idle
//   o_timeout           one-cycle pulse on watchdog abort
module mem_port_arbiter #(
  parameter int ADR_W      = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_valid,
  input  logic              i_m0_reqtyp,
  input  logic [ADR_W-1:0]  i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [1:0]        i_m0_size,
  output logic              o_m0_ready,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_valid,
  input  logic              i_m1_reqtyp,
  input  logic [ADR_W-1:0]  i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [1:0]        i_m1_size,
  output logic              o_m1_ready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_s_valid,
  output logic              o_s_reqtyp,
  output logic [ADR_W-1:0]  o_s_addr,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic [1:0]        o_s_size,
  input  logic              i_s_ready,
  input  logic [DATA_W-1:0] i_s_rdata,
  output logic              o_busy,
  output logic              o_timeout
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [3:0]  SL_W = 4'(STARVE_LIM);
  localparam logic [15:0] TO_W = 16'(TIMEOUT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [15:0] wd_cnt;
  logic        expire;

  // Read data is broadcast; only the ready pulse qualifies it.
  assign o_m0_rdata = i_s_rdata;
  assign o_m1_rdata = i_s_rdata;
  assign o_busy     = (state != IDLE);

  // Completion in the expiry cycle wins over the abort.
  assign expire    = (state != IDLE) && (wd_cnt == TO_W) && !i_s_ready;
  assign o_timeout = expire;

  always_comb begin
    o_s_valid  = 1'b0;
    o_s_reqtyp = 1'b0;
    o_s_addr   = '0;
    o_s_wdata  = '0;
    o_s_size   = '0;
    o_m0_ready = 1'b0;
    o_m1_ready = 1'b0;
    case (state)
      GNT0: begin
        o_s_valid  = i_m0_valid;
        o_s_reqtyp = i_m0_reqtyp;
        o_s_addr   = i_m0_addr;
        o_s_wdata  = i_m0_wdata;
        o_s_size   = i_m0_size;
        o_m0_ready = i_s_ready;
      end
      GNT1: begin
        o_s_valid  = i_m1_valid;
        o_s_reqtyp = i_m1_reqtyp;
        o_s_addr   = i_m1_addr;
        o_s_wdata  = i_m1_wdata;
        o_s_size   = i_m1_size;
        o_m1_ready = i_s_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // wd_cnt is cleared on every idle cycle, so it starts at 0 on entry.
          wd_cnt <= '0;
          if (i_m1_valid && (!i_m0_valid || starve_cnt == SL_W)) begin
            state      <= GNT1;
            starve_cnt <= '0;
          end else if (i_m0_valid) begin
            state <= GNT0;
            if (i_m1_valid)
              starve_cnt <= (starve_cnt == SL_W) ? SL_W : starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        GNT0, GNT1: begin
          // o_s_valid mirrors the granted requester's valid (withdrawal).
          if (i_s_ready || !o_s_valid || expire)
            state <= IDLE;
          else
            wd_cnt <= wd_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed stimulus for mem_port_arbiter with STARVE_LIM = 4, TIMEOUT = 8.
//   A transaction-level model predicts every output each cycle; literal
//   expectations pin read data, grant order and watchdog latency.
module tb_mem_port_arbiter;
  localparam int ADR_W = 32;
  localparam int DATA_W = 64;
  localparam int SLIM = 4;
  localparam int TOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_valid = 1'b0, m0_reqtyp = 1'b0;
  logic [ADR_W-1:0]  m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic [1:0]        m0_size = '0;
  logic              m1_valid = 1'b0, m1_reqtyp = 1'b0;
  logic [ADR_W-1:0]  m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic [1:0]        m1_size = '0;
  logic              s_ready = 1'b0;
  logic [DATA_W-1:0] s_rdata = '0;
  logic              m0_ready, m1_ready, s_valid, s_reqtyp, busy, timeout;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, s_wdata;
  logic [ADR_W-1:0]  s_addr;
  logic [1:0]        s_size;

  mem_port_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .STARVE_LIM(SLIM), .TIMEOUT(TOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_valid(m0_valid), .i_m0_reqtyp(m0_reqtyp), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .i_m0_size(m0_size),
    .o_m0_ready(m0_ready), .o_m0_rdata(m0_rdata),
    .i_m1_valid(m1_valid), .i_m1_reqtyp(m1_reqtyp), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .i_m1_size(m1_size),
    .o_m1_ready(m1_ready), .o_m1_rdata(m1_rdata),
    .o_s_valid(s_valid), .o_s_reqtyp(s_reqtyp), .o_s_addr(s_addr),
    .o_s_wdata(s_wdata), .o_s_size(s_size),
    .i_s_ready(s_ready), .i_s_rdata(s_rdata),
    .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which requester owns the port (-1 none), how many M0 grants M1
  // has sat through, and how long the current grant has waited.
  int owner = -1;
  int waited_grants = 0;
  int age = 0;

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; waited_grants = 0; age = 0;
    end else if (owner < 0) begin
      age = 0;
      if (m1_valid && (!m0_valid || waited_grants == SLIM)) begin
        owner = 1; waited_grants = 0;
      end else if (m0_valid) begin
        owner = 0;
        waited_grants = m1_valid ? ((waited_grants + 1 > SLIM) ? SLIM : waited_grants + 1) : 0;
      end else begin
        waited_grants = 0;
      end
    end else begin
      if (s_ready || !(owner == 0 ? m0_valid : m1_valid) || age == TOUT) owner = -1;
      else age++;
    end
  end

  // Observations used by the literal checks.
  int m0_rdy_cnt = 0, m1_rdy_cnt = 0, to_cnt = 0;
  logic [63:0] last_m0_rdata = '0;
  int grants[$];
  bit prev_busy = 1'b0;

  logic e_sv, e_typ;
  logic [ADR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wd;
  logic [1:0] e_size;

  always @(negedge clk) begin
    if (chk_en) begin
      e_sv = 0; e_typ = 0; e_addr = '0; e_wd = '0; e_size = '0;
      if (owner == 0) begin
        e_sv = m0_valid; e_typ = m0_reqtyp; e_addr = m0_addr; e_wd = m0_wdata; e_size = m0_size;
      end else if (owner == 1) begin
        e_sv = m1_valid; e_typ = m1_reqtyp; e_addr = m1_addr; e_wd = m1_wdata; e_size = m1_size;
      end
      chk("s_valid", 64'(s_valid), 64'(e_sv));
      chk("s_reqtyp", 64'(s_reqtyp), 64'(e_typ));
      chk("s_addr", 64'(s_addr), 64'(e_addr));
      chk("s_wdata", s_wdata, e_wd);
      chk("s_size", 64'(s_size), 64'(e_size));
      chk("m0_ready", 64'(m0_ready), 64'(owner == 0 && s_ready));
      chk("m1_ready", 64'(m1_ready), 64'(owner == 1 && s_ready));
      chk("m0_rdata", m0_rdata, s_rdata);
      chk("m1_rdata", m1_rdata, s_rdata);
      chk("busy", 64'(busy), 64'(owner >= 0));
      chk("timeout", 64'(timeout), 64'(owner >= 0 && age == TOUT && !s_ready));
      if (m0_ready) begin m0_rdy_cnt++; last_m0_rdata = m0_rdata; end
      if (m1_ready) m1_rdy_cnt++;
      if (timeout) to_cnt++;
      if (busy && !prev_busy) grants.push_back(int'(s_addr[15:12]));
      prev_busy = busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    m0_rdy_cnt = 0; m1_rdy_cnt = 0; to_cnt = 0; grants.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_order[6];
    exp_order = '{1, 1, 1, 1, 2, 1};
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    // Reset values checked directly before any traffic.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_svalid", 64'(s_valid), 64'd0);

    // 1: single M0 load, ready three cycles into the grant.
    clear_obs();
    m0_valid = 1; m0_addr = 32'h8000_0010; m0_size = 2'd3; m0_reqtyp = 0;
    cyc(1);
    chk("t1_svalid_c1", 64'(s_valid), 64'd1);
    cyc(2);
    s_ready = 1; s_rdata = 64'h1122_3344_5566_7788;
    cyc(1);
    s_ready = 0; s_rdata = '0; m0_valid = 0;
    chk("t1_idle", 64'(busy), 64'd0);
    cyc(2);
    chk("t1_rdy_cnt", 64'(m0_rdy_cnt), 64'd1);
    chk("t1_rdata", last_m0_rdata, 64'h1122_3344_5566_7788);

    // 2: contention with 1-cycle completions; ready held high in IDLE too.
    clear_obs();
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000; m0_size = 2'd2; m1_size = 2'd1;
    m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 64'h55;
    cyc(12);
    m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = '0;
    cyc(2);
    chk("t2_ngrants", 64'(grants.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < grants.size()) chk($sformatf("t2_grant%0d", i), 64'(grants[i]), 64'(exp_order[i]));

    // 3: M1 granted, withdraws before ready, pending M0 granted next.
    clear_obs();
    m1_valid = 1;
    cyc(1);
    m0_valid = 1;
    cyc(1);
    m1_valid = 0;
    #1;
    chk("t3_svalid_drop", 64'(s_valid), 64'd0);
    cyc(1);
    chk("t3_idle", 64'(busy), 64'd0);
    cyc(1);
    s_ready = 1;
    cyc(1);
    s_ready = 0; m0_valid = 0;
    cyc(2);
    chk("t3_m1_rdy", 64'(m1_rdy_cnt), 64'd0);
    chk("t3_m0_rdy", 64'(m0_rdy_cnt), 64'd1);
    chk("t3_ngrants", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) chk("t3_order", 64'(grants[0] * 16 + grants[1]), 64'h21);

    // 4a: watchdog with no ready at all.
    clear_obs();
    m0_valid = 1; m0_addr = 32'h0000_3000;
    cyc(1);
    n = 0;
    while (!timeout && n < 20) begin cyc(1); n++; end
    chk("t4_latency", 64'(n), 64'd8);
    cyc(1);
    m0_valid = 0;
    chk("t4_idle", 64'(busy), 64'd0);
    cyc(2);
    chk("t4_to_cnt", 64'(to_cnt), 64'd1);
    chk("t4_m0_rdy", 64'(m0_rdy_cnt), 64'd0);

    // 4b: ready on the expiry cycle wins.
    clear_obs();
    m0_valid = 1;
    cyc(9);
    s_ready = 1; s_rdata = 64'hCAFE;
    #1;
    chk("t4b_timeout", 64'(timeout), 64'd0);
    chk("t4b_ready", 64'(m0_ready), 64'd1);
    cyc(1);
    m0_valid = 0; s_ready = 0; s_rdata = '0;
    cyc(2);
    chk("t4b_to_cnt", 64'(to_cnt), 64'd0);

    // 5: reset mid-grant, then a late downstream ready.
    clear_obs();
    m0_valid = 1;
    cyc(2);
    rst = 1;
    cyc(1);
    rst = 0; m0_valid = 0; s_ready = 1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_svalid", 64'(s_valid), 64'd0);
    chk("t5_m0_ready", 64'(m0_ready), 64'd0);
    cyc(1);
    s_ready = 0;
    cyc(1);
    chk("t5_rdy_cnt", 64'(m0_rdy_cnt + m1_rdy_cnt), 64'd0);

    // 6: store passthrough held stable until ready.
    clear_obs();
    m0_valid = 1; m0_reqtyp = 1; m0_wdata = 64'hDEAD_BEEF; m0_size = 2'd2; m0_addr = 32'h40;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_reqtyp", 64'(s_reqtyp), 64'd1);
      chk("t6_wdata", s_wdata, 64'hDEAD_BEEF);
      chk("t6_size", 64'(s_size), 64'd2);
      cyc(1);
    end
    s_ready = 1;
    cyc(1);
    s_ready = 0; m0_valid = 0; m0_reqtyp = 0;
    cyc(3);
    chk("t6_rdy_cnt", 64'(m0_rdy_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory request port (the data-cache/bus side) between two requesters: M0 = LSU data port (high priority) and M1 = IFU fetch port.
- A registered grant FSM selects one requester and holds it until the downstream ready completes the transaction or the requester withdraws.
- A starvation counter bounds M1 waiting.
- A watchdog flags stalled transactions.

Parameters:
- ADR_W, 32, address width.
- DATA_W, 64, read/write data width.
- STARVE_LIM, 4, consecutive M0 grants issued while M1 is pending before M1 is forced next; legal 1..15.
- TIMEOUT, 1023, cycles in a grant state without downstream ready before abort; legal 1..65535.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_m0_valid  in  1  M0 request; held until o_m0_ready or withdrawn.
- i_m0_reqtyp  in  1  1 = store, 0 = load.
- i_m0_addr  in  ADR_W  M0 address.
- i_m0_wdata  in  DATA_W  M0 store data.
- i_m0_size  in  2  M0 access size (0 = B, 1 = H, 2 = W, 3 = D).
- o_m0_ready  out  1  one-cycle completion pulse to M0.
- o_m0_rdata  out  DATA_W  read data to M0.
- i_m1_valid, i_m1_reqtyp, i_m1_addr, i_m1_wdata, i_m1_size  in  1/1/ADR_W/DATA_W/2  same meaning as the M0 inputs, for M1.
- o_m1_ready, o_m1_rdata  out  1/DATA_W  same meaning as the M0 outputs, for M1.
- o_s_valid  out  1  downstream request valid.
- o_s_reqtyp, o_s_addr, o_s_wdata, o_s_size  out  1/ADR_W/DATA_W/2  downstream request fields.
- i_s_ready  in  1  downstream completion pulse.
- i_s_rdata  in  DATA_W  downstream read data, valid with i_s_ready.
- o_busy  out  1  FSM not in IDLE.
- o_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Reset: state = IDLE, starve_cnt = 0, wd_cnt = 0.
- Outputs at reset: o_s_valid = 0, o_m0_ready = 0, o_m1_ready = 0, o_busy = 0, o_timeout = 0.
- IDLE transitions:
  - Only M0 valid -> GNT0.
  - Only M1 valid -> GNT1.
  - Both valid -> GNT1 if starve_cnt == STARVE_LIM, otherwise GNT0.
  - Neither valid -> stay in IDLE.
- Latency: a request is presented downstream the cycle after it is first sampled in IDLE. Minimum 1 arbitration cycle.
- GNTx downstream drive (combinational):
  - o_s_valid = i_mx_valid.
  - o_s_reqtyp/addr/wdata/size = Mx fields.
  - o_mx_ready = i_s_ready.
  - Other master's ready = 0.
- In IDLE: o_s_valid = 0 and all fields are 0.
- rdata: i_s_rdata is broadcast to both o_m0_rdata and o_m1_rdata; only the ready pulse qualifies it.
- GNTx exits to IDLE on:
  - i_s_ready (completion);
  - i_mx_valid = 0 (withdrawal, e.g. flush/exception; no ready is returned);
  - watchdog expiry.
- Whenever GNTx exits to IDLE, the next grant requires a fresh IDLE arbitration cycle (1 bubble). No back-to-back grants.
- starve_cnt:
  - On entering GNT0 while i_m1_valid = 1: increment, saturating at STARVE_LIM.
  - On entering GNT1: clear to 0.
  - In IDLE with i_m1_valid = 0: clear to 0.
- Watchdog:
  - wd_cnt clears on any IDLE->GNTx entry and increments each cycle in GNTx without i_s_ready.
  - When wd_cnt == TIMEOUT and i_s_ready = 0: pulse o_timeout for 1 cycle, force state to IDLE, return no ready.
  - If i_s_ready arrives in the same cycle as expiry, completion wins and o_timeout stays 0.
- Simultaneous i_s_ready and requester withdrawal in the same cycle: treated as completion; o_mx_ready pulses.
- i_s_ready while in IDLE is ignored; no ready reaches either master.
- Reset mid-transaction: state returns to IDLE next edge, o_s_valid drops, and no ready is issued. Downstream must discard the transaction.
- o_busy = (state != IDLE).

Test Plan:
1. Single M0 load: i_m0_valid = 1, addr = 0x8000_0010, size = 3; i_s_ready after 3 cycles, rdata = 0x1122334455667788 -> o_s_valid rises at cycle 1; o_m0_ready pulses once with o_m0_rdata = 0x1122334455667788; FSM back to IDLE.
2. Contention, STARVE_LIM = 4: both masters valid continuously, each transaction completing in 1 cycle -> grant order M0, M0, M0, M0, M1, M0, …; M1 waits at most 4 M0 grants.
3. Withdrawal: M1 granted, then i_m1_valid drops 2 cycles later before any ready -> o_s_valid drops the same cycle, FSM in IDLE next cycle, o_m1_ready never asserts; a pending M0 is granted next.
4. Watchdog, TIMEOUT = 8: grant M0 and never assert i_s_ready -> o_timeout pulses exactly once 8 cycles after grant entry, FSM in IDLE, o_m0_ready = 0. Repeat with i_s_ready on the expiry cycle -> o_m0_ready = 1, o_timeout = 0.
5. Reset mid-grant: i_rst = 1 during GNT0 -> next cycle o_s_valid = 0, o_busy = 0, starve_cnt = 0; a late i_s_ready produces no master ready.
6. Store passthrough: M0 store with wdata = 0xDEADBEEF, size = 2 while M1 idle -> o_s_reqtyp = 1, o_s_wdata = 0xDEADBEEF, o_s_size = 2, all stable until i_s_ready.
